// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: register file with combinational reads, one write port and a busy scoreboard.
// Define REGFILE_BYPASS_EN to forward the writeback data, and clear its busy state, in the same cycle.
module regfile_scoreboard #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            we,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            stall,
    output logic [AW:0]     busy_cnt
);
    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [AW:0]      r_busy_cnt;
    logic             w_fwd1, w_fwd2, w_fwdw, w_waw, w_set, w_inc, w_dec;

`ifdef REGFILE_BYPASS_EN
    assign w_fwd1 = we && wr_addr != '0 && wr_addr == rs1_addr;
    assign w_fwd2 = we && wr_addr != '0 && wr_addr == rs2_addr;
    assign w_fwdw = we && wr_addr == issue_rd;
`else
    assign w_fwd1 = 1'b0;
    assign w_fwd2 = 1'b0;
    assign w_fwdw = 1'b0;
`endif

    assign rs1_data = (rs1_addr == '0) ? '0 : w_fwd1 ? wr_data : r_regs[rs1_addr];
    assign rs2_data = (rs2_addr == '0) ? '0 : w_fwd2 ? wr_data : r_regs[rs2_addr];
    assign rs1_busy = r_busy[rs1_addr] && rs1_addr != '0 && !w_fwd1;
    assign rs2_busy = r_busy[rs2_addr] && rs2_addr != '0 && !w_fwd2;
    assign w_waw    = r_busy[issue_rd] && issue_rd != '0 && !w_fwdw;
    assign stall    = issue_valid && (rs1_busy || rs2_busy || w_waw);
    assign w_set    = issue_valid && !stall && issue_rd != '0;
    // Set wins over a same-edge clear, so that case leaves the count unchanged.
    assign w_inc    = w_set && !r_busy[issue_rd];
    assign w_dec    = we && r_busy[wr_addr] && !(w_set && issue_rd == wr_addr);
    assign busy_cnt = r_busy_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            if (we && wr_addr != '0) r_regs[wr_addr] <= wr_data;
            if (we) r_busy[wr_addr] <= 1'b0;
            if (w_set) r_busy[issue_rd] <= 1'b1;
            r_busy_cnt <= r_busy_cnt + (AW+1)'(w_inc) - (AW+1)'(w_dec);
        end
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed scenarios plus random traffic checked against a behavioural model.
module tb_regfile_scoreboard;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_addr, rs2_addr, wr_addr, issue_rd;
    logic [63:0] rs1_data, rs2_data, wr_data;
    logic        we, issue_valid, rs1_busy, rs2_busy, stall;
    logic [5:0]  busy_cnt;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [63:0] m_regs [32];
    bit          m_busy [32];

    regfile_scoreboard dut (
        .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .we(we), .wr_addr(wr_addr),
        .wr_data(wr_data), .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .stall(stall), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit fwd(input logic [4:0] a);
        return BYP && we && wr_addr != 0 && wr_addr == a;
    endfunction

    function automatic logic [63:0] rd_e(input logic [4:0] a);
        if (a == 0) return 64'd0;
        return fwd(a) ? wr_data : m_regs[a];
    endfunction

    function automatic bit busy_e(input logic [4:0] a);
        return m_busy[a] && a != 0 && !fwd(a);
    endfunction

    function automatic bit stall_e();
        bit waw;
        waw = m_busy[issue_rd] && issue_rd != 0 && !(BYP && we && wr_addr == issue_rd);
        return issue_valid && (busy_e(rs1_addr) || busy_e(rs2_addr) || waw);
    endfunction

    function automatic logic [5:0] cnt_e();
        logic [5:0] c = 0;
        for (int i = 0; i < 32; i++) c += 6'(m_busy[i]);
        return c;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 0;
                m_busy[i] = 0;
            end
        end else begin
            bit s;
            s = stall_e();
            if (we && wr_addr != 0) m_regs[wr_addr] = wr_data;
            if (we) m_busy[wr_addr] = 0;
            if (issue_valid && !s && issue_rd != 0) m_busy[issue_rd] = 1;
        end
    end

    always @(negedge clk) begin
        chk("rs1_data", rs1_data, rd_e(rs1_addr));
        chk("rs2_data", rs2_data, rd_e(rs2_addr));
        chk("rs1_busy", 64'(rs1_busy), 64'(busy_e(rs1_addr)));
        chk("rs2_busy", 64'(rs2_busy), 64'(busy_e(rs2_addr)));
        chk("stall", 64'(stall), 64'(stall_e()));
        chk("busy_cnt", 64'(busy_cnt), 64'(cnt_e()));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input bit w, input logic [4:0] wa, input logic [63:0] wd,
                         input bit iv, input logic [4:0] rd, input logic [4:0] a1, input logic [4:0] a2);
        we = w; wr_addr = wa; wr_data = wd;
        issue_valid = iv; issue_rd = rd; rs1_addr = a1; rs2_addr = a2;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        cyc(); cyc();
        look();
        chk("reset_cnt", 64'(busy_cnt), 64'd0);
        chk("reset_rd", rs1_data, 64'd0);
        rst = 1'b0;
        cyc();
        // x0 writes and issues are inert
        drive(1, 0, 64'hFFFF, 1, 0, 0, 0);
        look();
        chk("x0_stall", 64'(stall), 64'd0);
        cyc();
        drive(0, 0, 0, 0, 0, 0, 0);
        look();
        chk("x0_rd", rs1_data, 64'd0);
        chk("x0_cnt", 64'(busy_cnt), 64'd0);
        cyc();
        // RAW on x7
        drive(0, 0, 0, 1, 7, 1, 2);
        cyc();
        drive(0, 0, 0, 1, 10, 0, 7);
        look();
        chk("raw_cnt", 64'(busy_cnt), 64'd1);
        chk("raw_stall", 64'(stall), 64'd1);
        chk("raw_busy", 64'(rs2_busy), 64'd1);
        cyc();
        drive(1, 7, 64'h1234, 1, 10, 0, 7);
        look();
`ifdef REGFILE_BYPASS_EN
        chk("raw_byp_stall", 64'(stall), 64'd0);
        chk("raw_byp_data", rs2_data, 64'h1234);
        cyc();
`else
        chk("raw_wb_stall", 64'(stall), 64'd1);
        cyc();
        drive(0, 0, 0, 1, 10, 0, 7);
        look();
        chk("raw_late_stall", 64'(stall), 64'd0);
        chk("raw_late_data", rs2_data, 64'h1234);
        cyc();
`endif
        drive(1, 10, 64'h55, 0, 0, 0, 0);
        cyc();
        drive(0, 0, 0, 0, 0, 0, 0);
        look();
        chk("raw_done_cnt", 64'(busy_cnt), 64'd0);
        cyc();
        // WAW on x9
        drive(0, 0, 0, 1, 9, 1, 2);
        cyc();
        look();
        chk("waw_stall", 64'(stall), 64'd1);
        cyc();
        look();
        chk("waw_cnt", 64'(busy_cnt), 64'd1);
        drive(1, 9, 64'h99, 0, 0, 0, 0);
        cyc();
`ifdef REGFILE_BYPASS_EN
        // set/clear collision on x4: set wins
        drive(0, 0, 0, 1, 4, 0, 0);
        cyc();
        drive(1, 4, 64'h44, 1, 4, 0, 0);
        look();
        chk("coll_stall", 64'(stall), 64'd0);
        cyc();
        drive(0, 0, 0, 0, 0, 4, 0);
        look();
        chk("coll_cnt", 64'(busy_cnt), 64'd1);
        chk("coll_busy", 64'(rs1_busy), 64'd1);
        drive(1, 4, 64'h44, 0, 0, 0, 0);
        cyc();
`endif
        // fill every register, then drain
        for (int r = 1; r < 32; r++) begin
            drive(0, 0, 0, 1, 5'(r), 0, 0);
            cyc();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        look();
        chk("fill_cnt", 64'(busy_cnt), 64'd31);
        for (int r = 1; r < 32; r++) begin
            drive(1, 5'(r), 64'(r) * 64'h1111, 0, 0, 0, 0);
            cyc();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        look();
        chk("drain_cnt", 64'(busy_cnt), 64'd0);
        for (int r = 1; r < 32; r++) begin
            drive(0, 0, 0, 0, 0, 5'(r), 5'(32 - r));
            look();
            chk("fill_rd1", rs1_data, 64'(r) * 64'h1111);
            chk("fill_rd2", rs2_data, 64'(32 - r) * 64'h1111);
        end
        cyc();
        // reset mid-run clears everything at once
        drive(1, 3, 64'hAB, 1, 5, 0, 0);
        cyc();
        drive(0, 0, 0, 1, 5, 3, 5);
        look();
        chk("pre_rst_rd", rs1_data, 64'hAB);
        chk("pre_rst_stall", 64'(stall), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_rd", rs1_data, 64'd0);
        chk("rst_cnt", 64'(busy_cnt), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        cyc();
        rst = 1'b0;
        // random traffic
        for (int k = 0; k < 4000; k++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom), {$urandom, $urandom},
                  1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom), 5'($urandom));
            rst = ($urandom_range(0, 299) == 0);
            cyc();
        end
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        cyc();
        look();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
